// File: rtl/usb_tx_arbiter.sv
// Arbitrates handshake and DATA0 transmit requests onto a single TX serializer,
// enforcing a start timeout and an inter-packet gap between packets.
`timescale 1ns/1ps
module usb_tx_arbiter #(
  parameter int unsigned IPG_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic       tx_start,
  output logic [1:0] tx_packet,
  output logic       hs_grant,
  output logic       data_grant,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int unsigned TMAX = (IPG_CYCLES > START_TIMEOUT) ? IPG_CYCLES : START_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
  localparam logic [TW-1:0] T_TO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] T_GAPLAST = TW'(IPG_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_ACT, S_ACTIVE, S_GAP} state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer, w_timer_inc;
  logic          r_fail, w_fail;
  logic          r_armed, w_armed;
  logic          r_tx_start, w_tx_start;
  logic [1:0]    r_tx_packet, w_tx_packet;
  logic          r_hs_grant, w_hs_grant;
  logic          r_data_grant, w_data_grant;
  logic          r_done, w_done;
  logic          r_err, w_err;
  logic          r_busy, w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_fail       <= 1'b0;
      r_armed      <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_packet  <= '0;
      r_hs_grant   <= 1'b0;
      r_data_grant <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_timer      <= w_timer;
      r_fail       <= w_fail;
      r_armed      <= w_armed;
      r_tx_start   <= w_tx_start;
      r_tx_packet  <= w_tx_packet;
      r_hs_grant   <= w_hs_grant;
      r_data_grant <= w_data_grant;
      r_done       <= w_done;
      r_err        <= w_err;
      r_busy       <= w_busy;
    end
  end

  assign w_timer_inc = (r_timer == T_SAT) ? r_timer : r_timer + 1'b1;

  always_comb begin
    w_state      = r_state;
    w_timer      = r_timer;
    w_fail       = r_fail;
    w_tx_packet  = r_tx_packet;
    w_tx_start   = 1'b0;
    w_hs_grant   = 1'b0;
    w_data_grant = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    // After reset a request must be seen low before it can be granted again
    w_armed      = r_armed | (!hs_req && !data_req);
    case (r_state)
      S_IDLE: begin
        w_timer = '0;
        // A grant visible this cycle means the requester has not yet dropped its request
        if (r_armed && !r_hs_grant && !r_data_grant) begin
          if (hs_req) begin
            w_hs_grant = 1'b1;
            if (hs_type == 2'd0) begin
              w_done = 1'b1;
              w_err  = 1'b1;
            end else begin
              w_tx_packet = hs_type;
              w_tx_start  = 1'b1;
              w_state     = S_START;
            end
          end else if (data_req) begin
            w_data_grant = 1'b1;
            if (buffer_occupancy > 7'd64) begin
              w_done = 1'b1;
              w_err  = 1'b1;
            end else begin
              w_tx_packet = 2'd0;
              w_tx_start  = 1'b1;
              w_state     = S_START;
            end
          end
        end
      end
      S_START: begin
        // Timer holds the number of clocks elapsed since tx_start was visible
        w_timer = w_timer_inc;
        w_state = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (tx_transfer_active) begin
          w_timer = '0;
          w_state = S_ACTIVE;
        end else if (r_timer >= T_TO_LAST) begin
          w_done  = 1'b1;
          w_err   = 1'b1;
          w_timer = '0;
          w_state = S_GAP;
        end else begin
          w_timer = w_timer_inc;
        end
      end
      S_ACTIVE: begin
        w_fail = r_fail | tx_error;
        if (!tx_transfer_active) begin
          w_done  = 1'b1;
          w_err   = w_fail;
          w_fail  = 1'b0;
          w_timer = '0;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_timer >= T_GAPLAST) begin
          w_timer = '0;
          w_state = S_IDLE;
        end else begin
          w_timer = w_timer_inc;
        end
      end
      default: begin
        w_timer = '0;
        w_fail  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  assign tx_start   = r_tx_start;
  assign tx_packet  = r_tx_packet;
  assign hs_grant   = r_hs_grant;
  assign data_grant = r_data_grant;
  assign done       = r_done;
  assign err        = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_usb_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_req = 1'b0;
  logic [1:0] hs_type = 2'd0;
  logic       data_req = 1'b0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       tx_transfer_active = 1'b0;
  logic       tx_error = 1'b0;
  logic       tx_start;
  logic [1:0] tx_packet;
  logic       hs_grant;
  logic       data_grant;
  logic       done;
  logic       err;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // {hs_grant, data_grant, tx_start, tx_packet[1:0], done, err, busy}
  logic [7:0] obs;
  assign obs = {hs_grant, data_grant, tx_start, tx_packet, done, err, busy};

  usb_tx_arbiter #(.IPG_CYCLES(16), .START_TIMEOUT(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .hs_req             (hs_req),
    .hs_type            (hs_type),
    .data_req           (data_req),
    .buffer_occupancy   (buffer_occupancy),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .hs_grant           (hs_grant),
    .data_grant         (data_grant),
    .done               (done),
    .err                (err),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (obs !== 8'b0_0_0_00_0_0_0) begin
      bad++; $display("FAIL reset_state got=%b want=%b", obs, 8'b0_0_0_00_0_0_0);
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (obs !== 8'b0_0_0_00_0_0_0) begin
      bad++; $display("FAIL post_reset_idle got=%b want=%b", obs, 8'b0_0_0_00_0_0_0);
    end
  endtask

  task automatic test_ack();
    hs_req = 1'b1; hs_type = 2'd1;
    tick();
    total++;
    if (obs !== 8'b1_0_1_01_0_0_1) begin
      bad++; $display("FAIL ack_grant got=%b want=%b", obs, 8'b1_0_1_01_0_0_1);
    end
    hs_req = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0_0_0_01_0_0_1) begin
      bad++; $display("FAIL ack_start_single got=%b want=%b", obs, 8'b0_0_0_01_0_0_1);
    end
    tx_transfer_active = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_01_0_0_1) begin
        bad++; $display("FAIL ack_active[%0d] got=%b want=%b", i, obs, 8'b0_0_0_01_0_0_1);
      end
    end
    tx_transfer_active = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0_0_0_01_1_0_1) begin
      bad++; $display("FAIL ack_done got=%b want=%b", obs, 8'b0_0_0_01_1_0_1);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_01_0_0_1) begin
        bad++; $display("FAIL ack_gap[%0d] got=%b want=%b", i, obs, 8'b0_0_0_01_0_0_1);
      end
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL ack_busy_low got=%b want=0", busy);
    end
  endtask

  task automatic test_priority();
    hs_req = 1'b1; hs_type = 2'd2; data_req = 1'b1; buffer_occupancy = 7'd10;
    tick();
    total++;
    if (obs !== 8'b1_0_1_10_0_0_1) begin
      bad++; $display("FAIL prio_nak_grant got=%b want=%b", obs, 8'b1_0_1_10_0_0_1);
    end
    hs_req = 1'b0;
    tx_transfer_active = 1'b1;
    repeat (4) tick();
    tx_transfer_active = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0_0_0_10_1_0_1) begin
      bad++; $display("FAIL prio_nak_done got=%b want=%b", obs, 8'b0_0_0_10_1_0_1);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_10_0_0_1) begin
        bad++; $display("FAIL prio_gap_nogrant[%0d] got=%b want=%b", i, obs, 8'b0_0_0_10_0_0_1);
      end
    end
    tick();
    total++;
    if ({data_grant, busy} !== 2'b00) begin
      bad++; $display("FAIL prio_idle got=%b want=00", {data_grant, busy});
    end
    tick();
    total++;
    if (obs !== 8'b0_1_1_00_0_0_1) begin
      bad++; $display("FAIL prio_data_grant got=%b want=%b", obs, 8'b0_1_1_00_0_0_1);
    end
    data_req = 1'b0;
    tx_transfer_active = 1'b1;
    repeat (2) tick();
    tx_transfer_active = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0_0_0_00_1_0_1) begin
      bad++; $display("FAIL prio_data_done got=%b want=%b", obs, 8'b0_0_0_00_1_0_1);
    end
    repeat (16) tick();
  endtask

  task automatic test_timeout();
    data_req = 1'b1; buffer_occupancy = 7'd0;
    tick();
    total++;
    if (obs !== 8'b0_1_1_00_0_0_1) begin
      bad++; $display("FAIL to_zero_len_grant got=%b want=%b", obs, 8'b0_1_1_00_0_0_1);
    end
    data_req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_00_0_0_1) begin
        bad++; $display("FAIL to_wait[%0d] got=%b want=%b", i, obs, 8'b0_0_0_00_0_0_1);
      end
    end
    tick();
    total++;
    if (obs !== 8'b0_0_0_00_1_1_1) begin
      bad++; $display("FAIL to_done_err got=%b want=%b", obs, 8'b0_0_0_00_1_1_1);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_00_0_0_1) begin
        bad++; $display("FAIL to_gap[%0d] got=%b want=%b", i, obs, 8'b0_0_0_00_0_0_1);
      end
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL to_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_error();
    data_req = 1'b1; buffer_occupancy = 7'd64;
    tick();
    total++;
    if (obs !== 8'b0_1_1_00_0_0_1) begin
      bad++; $display("FAIL err64_grant got=%b want=%b", obs, 8'b0_1_1_00_0_0_1);
    end
    data_req = 1'b0;
    tx_transfer_active = 1'b1;
    repeat (2) tick();
    tx_error = 1'b1;
    tick();
    tx_error = 1'b0;
    repeat (2) tick();
    total++;
    if (obs !== 8'b0_0_0_00_0_0_1) begin
      bad++; $display("FAIL err64_active got=%b want=%b", obs, 8'b0_0_0_00_0_0_1);
    end
    tx_transfer_active = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0_0_0_00_1_1_1) begin
      bad++; $display("FAIL err64_done_err got=%b want=%b", obs, 8'b0_0_0_00_1_1_1);
    end
    tick();
    total++;
    if (obs !== 8'b0_0_0_00_0_0_1) begin
      bad++; $display("FAIL err64_pulse_end got=%b want=%b", obs, 8'b0_0_0_00_0_0_1);
    end
    repeat (15) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL err64_idle got=%b want=0", busy);
    end
    data_req = 1'b1; buffer_occupancy = 7'd65;
    tick();
    total++;
    if (obs !== 8'b0_1_0_00_1_1_0) begin
      bad++; $display("FAIL occ65_reject got=%b want=%b", obs, 8'b0_1_0_00_1_1_0);
    end
    data_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_00_0_0_0) begin
        bad++; $display("FAIL occ65_no_start[%0d] got=%b want=%b", i, obs, 8'b0_0_0_00_0_0_0);
      end
    end
    hs_req = 1'b1; hs_type = 2'd0;
    tick();
    total++;
    if (obs !== 8'b1_0_0_00_1_1_0) begin
      bad++; $display("FAIL hs_illegal got=%b want=%b", obs, 8'b1_0_0_00_1_1_0);
    end
    hs_req = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0_0_0_00_0_0_0) begin
      bad++; $display("FAIL hs_illegal_after got=%b want=%b", obs, 8'b0_0_0_00_0_0_0);
    end
  endtask

  task automatic test_reset_mid();
    hs_req = 1'b1; hs_type = 2'd3;
    tick();
    total++;
    if (obs !== 8'b1_0_1_11_0_0_1) begin
      bad++; $display("FAIL rmid_stall_grant got=%b want=%b", obs, 8'b1_0_1_11_0_0_1);
    end
    hs_req = 1'b0;
    tx_transfer_active = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== 8'b0_0_0_00_0_0_0) begin
      bad++; $display("FAIL rmid_async got=%b want=%b", obs, 8'b0_0_0_00_0_0_0);
    end
    tx_transfer_active = 1'b0;
    data_req = 1'b1; buffer_occupancy = 7'd5;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== 8'b0_0_0_00_0_0_0) begin
        bad++; $display("FAIL rmid_no_grant[%0d] got=%b want=%b", i, obs, 8'b0_0_0_00_0_0_0);
      end
    end
    data_req = 1'b0;
    tick();
    data_req = 1'b1;
    tick();
    total++;
    if (obs !== 8'b0_1_1_00_0_0_1) begin
      bad++; $display("FAIL rmid_fresh_grant got=%b want=%b", obs, 8'b0_1_1_00_0_0_1);
    end
    data_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ack();
    test_priority();
    test_timeout();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
